// File: rtl/q_flop_pkg.sv
// Shared types for the Q-flop bank: FSM state enum and dual-rail ({rh_l,rl_l}) codes.
package q_flop_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } q_state_t;

  localparam logic [1:0] DR_UNRESOLVED = 2'b11;
  localparam logic [1:0] DR_HIGH       = 2'b01;
  localparam logic [1:0] DR_LOW        = 2'b10;
  localparam logic [1:0] DR_ILLEGAL    = 2'b00;

  function automatic logic [1:0] dr_encode(input logic value, input logic valid);
    if (!valid) return DR_UNRESOLVED;
    return value ? DR_HIGH : DR_LOW;
  endfunction

  function automatic logic dr_legal(input logic [1:0] rail);
    return rail != DR_ILLEGAL;
  endfunction

endpackage

// File: rtl/q_flop_bank_if.sv
// Bus of the Q-flop bank: capture request/ack, resolved word handshake and dual-rail lines.
interface q_flop_bank_if #(parameter int WIDTH = 8);
  // Handshake: a capture happens on an edge where sample=1 and ack=1; a word
  // is consumed on an edge where out_valid=1 and out_ready=1. out, rh_l and
  // rl_l stay stable while out_valid=1 until that consuming edge.
  logic [WIDTH-1:0] data;
  logic             sample;
  logic             ack;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rh_l;
  logic [WIDTH-1:0] rl_l;

  modport master (
    output data, sample, out_ready,
    input  ack, out, out_valid, rh_l, rl_l
  );

  modport slave (
    input  data, sample, out_ready,
    output ack, out, out_valid, rh_l, rl_l
  );
endinterface

// File: rtl/q_dual_rail_enc.sv
// One bit of registered dual-rail encoding: value+valid -> {rh_l,rl_l}, active low.
module q_dual_rail_enc
  import q_flop_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic value,
  input  logic valid,
  output logic rh_l,
  output logic rl_l
);

  logic [1:0] rail;

  always_ff @(posedge clock) begin
    if (reset) rail <= DR_UNRESOLVED;
    else       rail <= dr_encode(value, valid);
  end

  // Both rails low would claim the bit resolved high and low at once.
  always_ff @(posedge clock) begin
    if (!reset) assert (dr_legal(rail));
  end

  assign {rh_l, rl_l} = rail;

endmodule

// File: rtl/q_flop_bank.sv
// WIDTH-bit Q-flop bank: capture, SETTLE_CYCLES resolution window, then registered word + dual rail.
// Optional Q_FLOP_BANK_BACK2BACK_EN: release and recapture in the same HOLD edge.
module q_flop_bank
  import q_flop_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  q_flop_bank_if.slave  bus,
  output q_state_t      dbg_state
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  q_state_t         state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] capture, capture_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             ack_q, ack_d;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    capture_d = capture;
    out_d     = out_q;
    case (state)
      IDLE: begin
        if (bus.sample) begin
          capture_d = bus.data;
          cnt_d     = CNT_LOAD;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        if (cnt == '0) begin
          out_d   = capture;
          state_d = HOLD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      HOLD: begin
        // out keeps its last word after release; only the valid/rails drop.
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef Q_FLOP_BANK_BACK2BACK_EN
          if (bus.sample) begin
            capture_d = bus.data;
            cnt_d     = CNT_LOAD;
            state_d   = RESOLVE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == HOLD);
    ack_d       = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      capture     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      capture     <= capture_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
    end
  end

  // Rails are registered from the same next-state terms as out/out_valid,
  // so they are all ones exactly when out_valid is low.
  for (genvar i = 0; i < WIDTH; i++) begin : g_enc
    q_dual_rail_enc u_enc (
      .clock (clock),
      .reset (reset),
      .value (out_d[i]),
      .valid (out_valid_d),
      .rh_l  (bus.rh_l[i]),
      .rl_l  (bus.rl_l[i])
    );
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ack       = ack_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_q_flop_bank.sv
// Self-checking bench for q_flop_bank (WIDTH=8, SETTLE_CYCLES=2, plus a SETTLE_CYCLES=1 instance).
module tb_q_flop_bank;
  import q_flop_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int S1 = 1;
`ifdef Q_FLOP_BANK_BACK2BACK_EN
  localparam int PERIOD1 = S1 + 1;
`else
  localparam int PERIOD1 = S1 + 2;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  q_flop_bank_if #(.WIDTH(W)) bus  ();
  q_flop_bank_if #(.WIDTH(W)) bus1 ();
  q_state_t dbg_state, dbg_state1;

  q_flop_bank #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
    .clock(clock), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );
  q_flop_bank #(.WIDTH(W), .SETTLE_CYCLES(S1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .dbg_state(dbg_state1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one pending word, due to appear SETTLE cycles after acceptance.
  int           cyc = 0;
  logic         m_ack = 1'b1;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_word = '0;
  int           m_due = 0;
  bit           m_rose = 0;
  logic [W-1:0] exp_q[$];

  // driver: advance one edge, stepping the model with the inputs seen at that edge
  task automatic tick();
    logic r, s, rd;
    logic [W-1:0] d;
    r = reset; s = bus.sample; rd = bus.out_ready; d = bus.data;
    @(posedge clock);
    cyc++;
    m_rose = 0;
    if (r) begin
      m_ack = 1'b1; m_valid = 1'b0; m_out = '0; m_word = '0;
      exp_q.delete();
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0;
        m_ack   = 1'b1;
`ifdef Q_FLOP_BANK_BACK2BACK_EN
        if (s) begin
          m_word = d; m_ack = 1'b0; m_due = cyc + S;
          exp_q.push_back(d);
        end
`endif
      end
    end else if (!m_ack) begin
      if (cyc == m_due) begin
        m_valid = 1'b1; m_out = m_word; m_rose = 1;
      end
    end else if (s) begin
      m_word = d; m_ack = 1'b0; m_due = cyc + S;
      exp_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sample = 0; bus.out_ready = 0; bus.data = '0;
    bus1.sample = 0; bus1.out_ready = 0; bus1.data = '0;
    tick();
    n_cmp++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack got=%b exp=1", bus.ack); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", bus.out); end
    n_cmp++; if (bus.rh_l !== 8'hFF) begin n_fail++; $display("FAIL reset_rh_l got=%h exp=ff", bus.rh_l); end
    n_cmp++; if (bus.rl_l !== 8'hFF) begin n_fail++; $display("FAIL reset_rl_l got=%h exp=ff", bus.rl_l); end
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_capture();
    bus.data = 8'hA5; bus.sample = 1;
    tick();
    n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL cap_ack got=%b exp=0", bus.ack); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL cap_valid_n0 got=%b exp=0", bus.out_valid); end
    bus.data = 8'h00; bus.sample = 0;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL cap_valid_n1 got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.rh_l !== 8'hFF) begin n_fail++; $display("FAIL cap_rh_l_n1 got=%h exp=ff", bus.rh_l); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid_n2 got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.out !== 8'hA5) begin n_fail++; $display("FAIL cap_out got=%h exp=a5", bus.out); end
    n_cmp++; if (bus.rh_l !== 8'h5A) begin n_fail++; $display("FAIL cap_rh_l got=%h exp=5a", bus.rh_l); end
    n_cmp++; if (bus.rl_l !== 8'hA5) begin n_fail++; $display("FAIL cap_rl_l got=%h exp=a5", bus.rl_l); end
    n_cmp++; if (dbg_state !== HOLD) begin n_fail++; $display("FAIL cap_state got=%0d exp=%0d", dbg_state, HOLD); end
  endtask

  task automatic test_hold();
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.data = W'($urandom); bus.sample = 1;
      tick();
      n_cmp++; if (bus.out !== 8'hA5) begin n_fail++; $display("FAIL hold_out[%0d] got=%h exp=a5", i, bus.out); end
      n_cmp++; if (bus.rh_l !== 8'h5A || bus.rl_l !== 8'hA5) begin n_fail++; $display("FAIL hold_rails[%0d] got=%h/%h exp=5a/a5", i, bus.rh_l, bus.rl_l); end
      n_cmp++; if (bus.ack !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_hs[%0d] ack/valid got=%b/%b exp=0/1", i, bus.ack, bus.out_valid); end
    end
    bus.sample = 0; bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rel_ack got=%b exp=1", bus.ack); end
    n_cmp++; if (bus.rh_l !== 8'hFF || bus.rl_l !== 8'hFF) begin n_fail++; $display("FAIL rel_rails got=%h/%h exp=ff/ff", bus.rh_l, bus.rl_l); end
    n_cmp++; if (bus.out !== 8'hA5) begin n_fail++; $display("FAIL rel_out_kept got=%h exp=a5", bus.out); end
  endtask

  task automatic test_reset_mid();
    bus.data = 8'h3C; bus.sample = 1;
    tick();
    reset = 1;
    tick();
    reset = 0; bus.sample = 0;
    n_cmp++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rmid_ack got=%b exp=1", bus.ack); end
    n_cmp++; if (bus.out !== 8'h00) begin n_fail++; $display("FAIL rmid_out got=%h exp=00", bus.out); end
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rmid_state got=%0d exp=%0d", dbg_state, IDLE); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid[%0d] got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  // SETTLE_CYCLES=1 instance with sample/out_ready held high and data = edge index.
  task automatic test_throughput();
    reset = 1;
    tick();
    reset = 0;
    bus1.sample = 1; bus1.out_ready = 1;
    for (int k = 0; k < 12; k++) begin
      bus1.data = W'(k);
      tick();
      n_cmp++;
      if (bus1.out_valid !== ((k % PERIOD1) == 1)) begin
        n_fail++; $display("FAIL tput_valid[%0d] got=%b exp=%b", k, bus1.out_valid, (k % PERIOD1) == 1);
      end
      if ((k % PERIOD1) == 1) begin
        n_cmp++;
        if (bus1.out !== W'(k - 1)) begin n_fail++; $display("FAIL tput_out[%0d] got=%h exp=%h", k, bus1.out, W'(k - 1)); end
      end
    end
    bus1.sample = 0; bus1.out_ready = 0;
  endtask

  task automatic test_random();
    logic         p_valid, p_rdy, p_rst;
    logic [W-1:0] p_out, e_rail_h, e_rail_l;
    q_state_t     e_state;
    for (int i = 0; i < 10000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.sample    = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 2) == 0);
      bus.data      = W'($urandom);
      p_valid = bus.out_valid; p_out = bus.out; p_rdy = bus.out_ready; p_rst = reset;
      tick();
      e_rail_h = m_valid ? ~m_out : '1;
      e_rail_l = m_valid ?  m_out : '1;
      e_state  = m_ack ? IDLE : (m_valid ? HOLD : RESOLVE);
      n_cmp++; if (bus.ack !== m_ack || bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_hs@%0d ack/valid got=%b/%b exp=%b/%b", i, bus.ack, bus.out_valid, m_ack, m_valid); end
      n_cmp++; if (bus.out !== m_out) begin n_fail++; $display("FAIL rnd_out@%0d got=%h exp=%h", i, bus.out, m_out); end
      n_cmp++; if (bus.rh_l !== e_rail_h || bus.rl_l !== e_rail_l) begin n_fail++; $display("FAIL rnd_rails@%0d got=%h/%h exp=%h/%h", i, bus.rh_l, bus.rl_l, e_rail_h, e_rail_l); end
      n_cmp++; if (dbg_state !== e_state) begin n_fail++; $display("FAIL rnd_state@%0d got=%0d exp=%0d", i, dbg_state, e_state); end
      n_cmp++; if ((~bus.rh_l & ~bus.rl_l) !== '0) begin n_fail++; $display("FAIL rnd_illegal_rail@%0d rh_l=%h rl_l=%h exp no bit both low", i, bus.rh_l, bus.rl_l); end
      if (p_valid && !p_rdy && !p_rst) begin
        n_cmp++; if (bus.out !== p_out) begin n_fail++; $display("FAIL rnd_stable@%0d got=%h exp=%h", i, bus.out, p_out); end
      end
      if (m_rose) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_sb_empty@%0d got=%h exp=<queued word>", i, bus.out);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (bus.out !== e) begin n_fail++; $display("FAIL rnd_sb@%0d got=%h exp=%h", i, bus.out, e); end
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_hold();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
